// File: rtl/hm_trn_tx_buf.sv
// rtl/hm_trn_tx_buf.sv - store-and-forward TLP buffer driving one TRN transmit arbiter master port
module hm_trn_tx_buf #(
    parameter int AW = 5
) (
    input  logic          trn_clk,
    input  logic          trn_rst_n,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [63:0]   wr_data,
    input  logic          wr_rem_n,
    input  logic          wr_eof,
    output logic [AW:0]   pkt_cnt,
    output logic [AW:0]   level,
    output logic          m_trn_cyc_n,
    output logic [63:0]   m_trn_td,
    output logic          m_trn_trem_n,
    output logic          m_trn_tsof_n,
    output logic          m_trn_teof_n,
    output logic          m_trn_tsrc_rdy_n,
    output logic          m_trn_tsrc_dsc_n,
    output logic          m_trn_terrfwd_n,
    output logic          m_trn_tstr_n,
    input  logic          m_trn_tdst_rdy_n,
    input  logic [5:0]    m_trn_tbuf_av,
    input  logic          m_trn_terr_drop_n
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Entry layout: {eof, rem_n, data}
    logic [65:0]  mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [65:0]  head;
    logic         full;
    logic         wr_fire;
    logic         rd_fire;
    logic         eof_in;
    logic         eof_out;
    logic         first;
    state_t       state;
    state_t       state_nxt;
    logic         unused_inputs;

    assign unused_inputs = ^{m_trn_tbuf_av, m_trn_terr_drop_n};

    assign full     = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
    assign wr_ready = ~full;
    assign wr_fire  = wr_valid & ~full;
    assign head     = mem[rd_ptr[AW-1:0]];
    assign rd_fire  = (state == ST_XFER) & ~m_trn_tdst_rdy_n;
    assign eof_in   = wr_fire & wr_eof;
    assign eof_out  = rd_fire & head[65];
    assign level    = wr_ptr - rd_ptr;

    always_ff @(posedge trn_clk) begin
        if (wr_fire) begin
            mem[wr_ptr[AW-1:0]] <= {wr_eof, wr_rem_n, wr_data};
        end
    end

    always_ff @(posedge trn_clk or negedge trn_rst_n) begin
        if (!trn_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Only whole TLPs are counted, so the bus is never requested for a partial packet.
    always_ff @(posedge trn_clk or negedge trn_rst_n) begin
        if (!trn_rst_n) begin
            pkt_cnt <= '0;
        end else begin
            case ({eof_in, eof_out})
                2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
                2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
                default: pkt_cnt <= pkt_cnt;
            endcase
        end
    end

    always_ff @(posedge trn_clk or negedge trn_rst_n) begin
        if (!trn_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge trn_clk or negedge trn_rst_n) begin
        if (!trn_rst_n) begin
            first <= 1'b0;
        end else if (rd_fire) begin
            first <= 1'b0;
        end else if ((state == ST_IDLE) && (pkt_cnt != '0)) begin
            first <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (pkt_cnt != '0) begin
                    state_nxt = ST_XFER;
                end
            end
            ST_XFER: begin
                if (eof_out) begin
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Bus outputs depend on state only, so they hold steady while the destination stalls.
    always_comb begin
        m_trn_cyc_n      = 1'b1;
        m_trn_tsrc_rdy_n = 1'b1;
        m_trn_td         = 64'd0;
        m_trn_trem_n     = 1'b1;
        m_trn_tsof_n     = 1'b1;
        m_trn_teof_n     = 1'b1;
        if (state == ST_XFER) begin
            m_trn_cyc_n      = 1'b0;
            m_trn_tsrc_rdy_n = 1'b0;
            m_trn_td         = head[63:0];
            m_trn_trem_n     = head[64];
            m_trn_tsof_n     = ~first;
            m_trn_teof_n     = ~head[65];
        end
    end

    assign m_trn_tsrc_dsc_n = 1'b1;
    assign m_trn_terrfwd_n  = 1'b1;
    assign m_trn_tstr_n     = 1'b1;

endmodule

// File: tb/tb_hm_trn_tx_buf.sv
// tb/tb_hm_trn_tx_buf.sv - self-checking bench for hm_trn_tx_buf
module tb_hm_trn_tx_buf;

    logic        trn_clk;
    logic        trn_rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [63:0] wr_data;
    logic        wr_rem_n;
    logic        wr_eof;
    logic [5:0]  pkt_cnt;
    logic [5:0]  level;
    logic        m_trn_cyc_n;
    logic [63:0] m_trn_td;
    logic        m_trn_trem_n;
    logic        m_trn_tsof_n;
    logic        m_trn_teof_n;
    logic        m_trn_tsrc_rdy_n;
    logic        m_trn_tsrc_dsc_n;
    logic        m_trn_terrfwd_n;
    logic        m_trn_tstr_n;
    logic        m_trn_tdst_rdy_n;
    logic [5:0]  m_trn_tbuf_av;
    logic        m_trn_terr_drop_n;

    hm_trn_tx_buf #(.AW(5)) dut (
        .trn_clk           (trn_clk),
        .trn_rst_n         (trn_rst_n),
        .wr_valid          (wr_valid),
        .wr_ready          (wr_ready),
        .wr_data           (wr_data),
        .wr_rem_n          (wr_rem_n),
        .wr_eof            (wr_eof),
        .pkt_cnt           (pkt_cnt),
        .level             (level),
        .m_trn_cyc_n       (m_trn_cyc_n),
        .m_trn_td          (m_trn_td),
        .m_trn_trem_n      (m_trn_trem_n),
        .m_trn_tsof_n      (m_trn_tsof_n),
        .m_trn_teof_n      (m_trn_teof_n),
        .m_trn_tsrc_rdy_n  (m_trn_tsrc_rdy_n),
        .m_trn_tsrc_dsc_n  (m_trn_tsrc_dsc_n),
        .m_trn_terrfwd_n   (m_trn_terrfwd_n),
        .m_trn_tstr_n      (m_trn_tstr_n),
        .m_trn_tdst_rdy_n  (m_trn_tdst_rdy_n),
        .m_trn_tbuf_av     (m_trn_tbuf_av),
        .m_trn_terr_drop_n (m_trn_terr_drop_n)
    );

    initial trn_clk = 1'b0;
    always #5 trn_clk = ~trn_clk;

    typedef struct {
        logic        wv;
        logic [63:0] wd;
        logic        wrem;
        logic        weof;
        logic        rdy_n;
        logic [3:0]  ctl;
        logic [63:0] td;
        logic        trem;
        logic [5:0]  pkt;
        logic [5:0]  lvl;
        logic        wrdy;
    } vec_t;

    typedef struct {
        logic [63:0] d;
        logic        rem_n;
        logic        eof;
    } wbeat_t;

    typedef struct {
        logic [63:0] td;
        logic        rem_n;
        logic        sof_n;
        logic        eof_n;
        int          gap;
    } beat_t;

    int total = 0;
    int bad = 0;
    int hi_cnt = 0;
    int lo_cnt = 0;
    vec_t   vt[20];
    wbeat_t wq[$];
    beat_t  rq[$];
    beat_t  eq[$];

    localparam logic [63:0] D0 = 64'hA0A0_0000_1111_0000;
    localparam logic [63:0] D1 = 64'hA1A1_0000_2222_0001;
    localparam logic [63:0] D2 = 64'hA2A2_0000_3333_0002;
    localparam logic [63:0] E0 = 64'hB0B0_5555_0000_0010;
    localparam logic [63:0] E1 = 64'hB1B1_6666_0000_0011;
    localparam logic [63:0] E2 = 64'hB2B2_7777_0000_0012;
    localparam logic [3:0]  OFF = 4'b1111;

    function automatic vec_t v(logic wv, logic [63:0] wd, logic wrem, logic weof, logic rdy_n,
                               logic [3:0] ctl, logic [63:0] td, logic trem,
                               logic [5:0] pkt, logic [5:0] lvl, logic wrdy);
        vec_t r;
        r.wv = wv; r.wd = wd; r.wrem = wrem; r.weof = weof; r.rdy_n = rdy_n;
        r.ctl = ctl; r.td = td; r.trem = trem; r.pkt = pkt; r.lvl = lvl; r.wrdy = wrdy;
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic push_tlp(input int n, input logic [63:0] base, input logic last_rem);
        wbeat_t w;
        beat_t  e;
        for (int i = 0; i < n; i++) begin
            w.d = base + 64'(i);
            w.rem_n = (i == n - 1) ? last_rem : 1'b0;
            w.eof = (i == n - 1);
            wq.push_back(w);
            e.td = w.d; e.rem_n = w.rem_n; e.sof_n = (i != 0); e.eof_n = (i != n - 1); e.gap = 0;
            eq.push_back(e);
        end
    endtask

    // One clock: drive the write head and tdst_rdy_n, record any accepted output beat.
    task automatic step(input logic rdy_n);
        beat_t b;
        if (wq.size() > 0) begin
            wr_valid = 1'b1; wr_data = wq[0].d; wr_rem_n = wq[0].rem_n; wr_eof = wq[0].eof;
        end else begin
            wr_valid = 1'b0; wr_data = 64'd0; wr_rem_n = 1'b0; wr_eof = 1'b0;
        end
        m_trn_tdst_rdy_n = rdy_n;
        #1;
        if (m_trn_cyc_n) hi_cnt++;
        else lo_cnt++;
        if (!m_trn_tsrc_rdy_n && !rdy_n) begin
            b.td = m_trn_td; b.rem_n = m_trn_trem_n; b.sof_n = m_trn_tsof_n;
            b.eof_n = m_trn_teof_n; b.gap = hi_cnt;
            rq.push_back(b);
            hi_cnt = 0;
        end
        if (wr_valid && wr_ready) void'(wq.pop_front());
        @(negedge trn_clk);
    endtask

    task automatic do_reset();
        trn_rst_n = 1'b0;
        wr_valid = 1'b0; wr_eof = 1'b0; wr_rem_n = 1'b0; wr_data = 64'd0;
        m_trn_tdst_rdy_n = 1'b1;
        wq.delete(); rq.delete(); eq.delete();
        @(negedge trn_clk);
        trn_rst_n = 1'b1;
        @(negedge trn_clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        trn_rst_n = 1'b0;
        wr_valid = 1'b0; wr_data = 64'd0; wr_rem_n = 1'b0; wr_eof = 1'b0;
        m_trn_tdst_rdy_n = 1'b1; m_trn_tbuf_av = 6'd0; m_trn_terr_drop_n = 1'b1;

        // Tests 1 and 2: 3-beat TLP always ready, then with stalls 1,0,1,1,0,0.
        vt[0]  = v(1, D0, 0, 0, 0, OFF,     64'd0, 1, 0, 0, 1);
        vt[1]  = v(1, D1, 0, 0, 0, OFF,     64'd0, 1, 0, 1, 1);
        vt[2]  = v(1, D2, 1, 1, 0, OFF,     64'd0, 1, 0, 2, 1);
        vt[3]  = v(0, 0,  0, 0, 0, OFF,     64'd0, 1, 1, 3, 1);
        vt[4]  = v(0, 0,  0, 0, 0, 4'b0001, D0,    0, 1, 3, 1);
        vt[5]  = v(0, 0,  0, 0, 0, 4'b0011, D1,    0, 1, 2, 1);
        vt[6]  = v(0, 0,  0, 0, 0, 4'b0010, D2,    1, 1, 1, 1);
        vt[7]  = v(0, 0,  0, 0, 0, OFF,     64'd0, 1, 0, 0, 1);
        vt[8]  = v(0, 0,  0, 0, 0, OFF,     64'd0, 1, 0, 0, 1);
        vt[9]  = v(1, E0, 0, 0, 1, OFF,     64'd0, 1, 0, 0, 1);
        vt[10] = v(1, E1, 0, 0, 1, OFF,     64'd0, 1, 0, 1, 1);
        vt[11] = v(1, E2, 1, 1, 1, OFF,     64'd0, 1, 0, 2, 1);
        vt[12] = v(0, 0,  0, 0, 1, OFF,     64'd0, 1, 1, 3, 1);
        vt[13] = v(0, 0,  0, 0, 1, 4'b0001, E0,    0, 1, 3, 1);
        vt[14] = v(0, 0,  0, 0, 0, 4'b0001, E0,    0, 1, 3, 1);
        vt[15] = v(0, 0,  0, 0, 1, 4'b0011, E1,    0, 1, 2, 1);
        vt[16] = v(0, 0,  0, 0, 1, 4'b0011, E1,    0, 1, 2, 1);
        vt[17] = v(0, 0,  0, 0, 0, 4'b0011, E1,    0, 1, 2, 1);
        vt[18] = v(0, 0,  0, 0, 0, 4'b0010, E2,    1, 1, 1, 1);
        vt[19] = v(0, 0,  0, 0, 0, OFF,     64'd0, 1, 0, 0, 1);

        #2;
        chk("rst_async_outputs", 128'({m_trn_cyc_n, m_trn_tsrc_rdy_n, m_trn_tsof_n, m_trn_teof_n,
                                       m_trn_td, m_trn_trem_n, pkt_cnt, level, wr_ready}),
            128'({OFF, 64'd0, 1'b1, 6'd0, 6'd0, 1'b1}));
        chk("rst_tied", 128'({m_trn_tsrc_dsc_n, m_trn_terrfwd_n, m_trn_tstr_n}), 128'(3'b111));
        @(negedge trn_clk);
        trn_rst_n = 1'b1;
        @(negedge trn_clk);

        for (int i = 0; i < 20; i++) begin
            wr_valid = vt[i].wv; wr_data = vt[i].wd; wr_rem_n = vt[i].wrem; wr_eof = vt[i].weof;
            m_trn_tdst_rdy_n = vt[i].rdy_n;
            #1;
            chk($sformatf("row%0d", i),
                128'({m_trn_cyc_n, m_trn_tsrc_rdy_n, m_trn_tsof_n, m_trn_teof_n,
                      m_trn_td, m_trn_trem_n, pkt_cnt, level, wr_ready}),
                128'({vt[i].ctl, vt[i].td, vt[i].trem, vt[i].pkt, vt[i].lvl, vt[i].wrdy}));
            @(negedge trn_clk);
        end

        // Test 3: two 1-beat TLPs back to back.
        do_reset();
        push_tlp(1, 64'hC0C0_0000_0000_0000, 1'b1);
        push_tlp(1, 64'hC1C1_0000_0000_0000, 1'b0);
        hi_cnt = 0;
        for (int c = 0; c < 30 && rq.size() < 2; c++) step(1'b0);
        chk("t3_count", 128'(rq.size()), 128'(2));
        if (rq.size() == 2) begin
            for (int i = 0; i < 2; i++)
                chk($sformatf("t3_beat%0d", i),
                    128'({rq[i].td, rq[i].rem_n, rq[i].sof_n, rq[i].eof_n}),
                    128'({eq[i].td, eq[i].rem_n, 1'b0, 1'b0}));
            chk("t3_gap", 128'(rq[1].gap), 128'(2));
        end

        // Test 4: 32 beats without eof fill the buffer and never request the bus.
        do_reset();
        lo_cnt = 0;
        for (int i = 0; i < 34; i++) begin
            wr_valid = 1'b1; wr_data = 64'(i); wr_eof = 1'b0; wr_rem_n = 1'b0;
            m_trn_tdst_rdy_n = 1'b0;
            #1;
            if (!m_trn_cyc_n) lo_cnt++;
            @(negedge trn_clk);
        end
        #1;
        chk("t4_full", 128'({wr_ready, level, pkt_cnt}), 128'({1'b0, 6'd32, 6'd0}));
        chk("t4_no_req", 128'(lo_cnt), 128'(0));
        do_reset();
        #1;
        chk("t4_after_rst", 128'({wr_ready, level, pkt_cnt, m_trn_cyc_n}),
            128'({1'b1, 6'd0, 6'd0, 1'b1}));
        @(negedge trn_clk);

        // Test 5: full buffer of two TLPs drained while a third wraps the pointers.
        do_reset();
        push_tlp(16, 64'hD000_0000_0000_0000, 1'b0);
        push_tlp(16, 64'hD100_0000_0000_0000, 1'b1);
        for (int c = 0; c < 60 && wq.size() > 0; c++) step(1'b1);
        #1;
        chk("t5_full", 128'({wr_ready, level, pkt_cnt, m_trn_cyc_n}),
            128'({1'b0, 6'd32, 6'd2, 1'b0}));
        @(negedge trn_clk);
        push_tlp(5, 64'hD200_0000_0000_0000, 1'b1);
        step(1'b0);
        chk("t5_wr_ready_rise", 128'({wr_ready, level}), 128'({1'b1, 6'd31}));
        for (int c = 0; c < 150 && rq.size() < 37; c++) step(1'b0);
        chk("t5_count", 128'(rq.size()), 128'(37));
        for (int i = 0; i < rq.size() && i < eq.size(); i++)
            chk($sformatf("t5_beat%0d", i),
                128'({rq[i].td, rq[i].rem_n, rq[i].sof_n, rq[i].eof_n}),
                128'({eq[i].td, eq[i].rem_n, eq[i].sof_n, eq[i].eof_n}));
        repeat (3) step(1'b0);
        #1;
        chk("t5_empty", 128'({level, pkt_cnt, wr_ready}), 128'({6'd0, 6'd0, 1'b1}));
        @(negedge trn_clk);

        // Test 6: asynchronous reset in the middle of a 4-beat TLP.
        do_reset();
        push_tlp(4, 64'hE000_0000_0000_0000, 1'b1);
        for (int c = 0; c < 20 && rq.size() < 2; c++) step(1'b0);
        chk("t6_two_beats", 128'(rq.size()), 128'(2));
        #1;
        chk("t6_mid_xfer", 128'({m_trn_cyc_n, m_trn_tsrc_rdy_n, m_trn_td}),
            128'({1'b0, 1'b0, 64'hE000_0000_0000_0002}));
        #1;
        trn_rst_n = 1'b0;
        #1;
        chk("t6_async_rst", 128'({m_trn_cyc_n, m_trn_tsrc_rdy_n, m_trn_tsof_n, m_trn_teof_n,
                                  m_trn_td, m_trn_trem_n, pkt_cnt, level, wr_ready}),
            128'({OFF, 64'd0, 1'b1, 6'd0, 6'd0, 1'b1}));
        @(negedge trn_clk);
        trn_rst_n = 1'b1;
        wq.delete(); rq.delete(); eq.delete();
        @(negedge trn_clk);
        lo_cnt = 0;
        for (int c = 0; c < 10; c++) step(1'b0);
        chk("t6_quiet", 128'({lo_cnt, rq.size()}), 128'({32'd0, 32'd0}));
        push_tlp(1, 64'hF00D_0000_0000_0001, 1'b1);
        for (int c = 0; c < 20 && rq.size() < 1; c++) step(1'b0);
        chk("t6_new_count", 128'(rq.size()), 128'(1));
        if (rq.size() == 1)
            chk("t6_new_beat", 128'({rq[0].td, rq[0].rem_n, rq[0].sof_n, rq[0].eof_n}),
                128'({64'hF00D_0000_0000_0001, 1'b1, 1'b0, 1'b0}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
